// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port, redirect input and decode-side
// instruction buffer handshake. The master modport is the fetch unit.
// IFU_MISALIGN_CHECK_EN adds the MISALIGN status signal.
interface instr_fetch_unit_if #(
  parameter int ADDRESS_SIZE = 16,
  parameter int WORD_SIZE    = 32
);
  logic [ADDRESS_SIZE-1:0] IMEM_ADDRESS;
  logic                    IMEM_ENABLE;
  logic                    IMEM_DATA_READY;
  logic [WORD_SIZE-1:0]    IMEM_DATA;
  logic                    REDIRECT;
  logic [ADDRESS_SIZE-1:0] REDIRECT_PC;
  logic                    IR_READY;
  logic                    IR_VALID;
  logic [WORD_SIZE-1:0]    IR;
  logic [ADDRESS_SIZE-1:0] IR_PC;
`ifdef IFU_MISALIGN_CHECK_EN
  logic                    MISALIGN;

  modport master (
    output IMEM_ADDRESS, IMEM_ENABLE, IR_VALID, IR, IR_PC, MISALIGN,
    input  IMEM_DATA_READY, IMEM_DATA, REDIRECT, REDIRECT_PC, IR_READY
  );
  modport slave (
    input  IMEM_ADDRESS, IMEM_ENABLE, IR_VALID, IR, IR_PC, MISALIGN,
    output IMEM_DATA_READY, IMEM_DATA, REDIRECT, REDIRECT_PC, IR_READY
  );
`else
  modport master (
    output IMEM_ADDRESS, IMEM_ENABLE, IR_VALID, IR, IR_PC,
    input  IMEM_DATA_READY, IMEM_DATA, REDIRECT, REDIRECT_PC, IR_READY
  );
  modport slave (
    input  IMEM_ADDRESS, IMEM_ENABLE, IR_VALID, IR, IR_PC,
    output IMEM_DATA_READY, IMEM_DATA, REDIRECT, REDIRECT_PC, IR_READY
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// DLX instruction fetch stage: owns the PC, issues one-word ROM reads and
// buffers returned words with their PCs in a small FIFO for decode.
// Redirects flush the buffer and discard the in-flight response.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect traps
// into HALT and raises sticky MISALIGN); without it the low PC bits of a
// redirect target are forced to zero.
module instr_fetch_unit #(
  parameter int                      ADDRESS_SIZE = 16,
  parameter int                      WORD_SIZE    = 32,
  parameter int                      FIFO_DEPTH   = 4,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int STEP  = WORD_SIZE / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_SIZE-1:0] STEP_C   = ADDRESS_SIZE'(STEP);
  localparam logic [ADDRESS_SIZE-1:0] OFS_MASK = ADDRESS_SIZE'(STEP - 1);
  localparam logic [CNT_W:0]          DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_e;
`endif

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic [ADDRESS_SIZE-1:0] req_pc_q, req_pc_d;
  logic                    inflight_q, inflight_d;
  logic                    drop_q, drop_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    misalign_q, misalign_d;

  logic [WORD_SIZE-1:0]    word_mem [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0] pc_mem   [FIFO_DEPTH];

  logic            issue, push, pop, flush, valid, mis_target;
  logic [CNT_W:0]  occupancy;

  assign valid      = (count_q != '0);
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue      = (state_q == S_RUN) && !bus.REDIRECT && (occupancy < DEPTH_C);
  assign push       = bus.IMEM_DATA_READY && inflight_q && !drop_q;
  assign pop        = valid && bus.IR_READY;
  assign mis_target = |(bus.REDIRECT_PC & OFS_MASK);
`ifdef IFU_MISALIGN_CHECK_EN
  assign flush      = bus.REDIRECT || (state_q == S_HALT);
`else
  assign flush      = bus.REDIRECT;
`endif

  // Next-state logic for the FSM, PC, request tracking and FIFO pointers.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    drop_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = state_q;
    endcase

    if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + STEP_C;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    if (bus.REDIRECT) begin
      drop_d = inflight_q;
`ifdef IFU_MISALIGN_CHECK_EN
      pc_d = bus.REDIRECT_PC;
      if (mis_target) begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end else begin
        misalign_d = 1'b0;
        state_d    = S_RUN;
      end
`else
      pc_d = bus.REDIRECT_PC & ~OFS_MASK;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // PC, request tracking and FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO storage write; a redirect discards the same-cycle push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; empty entries are masked at the outputs.
    if (push && !flush) begin
      word_mem[wr_ptr_q] <= bus.IMEM_DATA;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign bus.IMEM_ADDRESS = pc_q;
  assign bus.IMEM_ENABLE  = issue;
  assign bus.IR_VALID     = valid;
  assign bus.IR           = valid ? word_mem[rd_ptr_q] : '0;
  assign bus.IR_PC        = valid ? pc_mem[rd_ptr_q]   : '0;
`ifdef IFU_MISALIGN_CHECK_EN
  assign bus.MISALIGN     = misalign_q;
`else
  logic unused_ok;
  assign unused_ok = mis_target;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table covering
// reset, streaming, backpressure, redirect flush, PC wrap and misaligned
// redirect, plus hand-written latency and asynchronous-reset sequences.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDRESS_SIZE(16), .WORD_SIZE(32)) bus ();

  instr_fetch_unit #(
    .ADDRESS_SIZE(16), .WORD_SIZE(32), .FIFO_DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ROM contents: the DLX first instruction at 0, address-tagged words elsewhere.
  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return (a == 16'h0000) ? 32'h2001_0005 : {16'hC0DE, a};
  endfunction

  // One-cycle-latency instruction ROM.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.IMEM_DATA_READY <= 1'b0;
      bus.IMEM_DATA       <= '0;
    end else begin
      bus.IMEM_DATA_READY <= bus.IMEM_ENABLE;
      bus.IMEM_DATA       <= rom_word(bus.IMEM_ADDRESS);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        en;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] irpc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rdy, input logic redir,
                              input logic [15:0] rpc, input logic en,
                              input logic [15:0] addr, input logic valid,
                              input logic [15:0] irpc, input logic mis);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.en = en; v.addr = addr; v.valid = valid; v.irpc = irpc; v.mis = mis;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = '0;
    bus.IR_READY    = 1'b0;

    // Reset release, decode always ready: IR_PC 0, 4, 8 on consecutive cycles.
    add(1,1,0,16'h0000, 0,16'h0000,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0000,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0004,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0008,1,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h000C,1,16'h0004,0);
    add(1,1,0,16'h0000, 1,16'h0010,1,16'h0008,0);
    // Asynchronous reset mid-stream, then release with decode stalled.
    add(0,0,0,16'h0000, 0,16'h0000,0,16'h0000,0);
    add(0,0,0,16'h0000, 0,16'h0000,0,16'h0000,0);
    add(1,0,0,16'h0000, 0,16'h0000,0,16'h0000,0);
    add(1,0,0,16'h0000, 1,16'h0000,0,16'h0000,0);
    add(1,0,0,16'h0000, 1,16'h0004,0,16'h0000,0);
    add(1,0,0,16'h0000, 1,16'h0008,1,16'h0000,0);
    add(1,0,0,16'h0000, 1,16'h000C,1,16'h0000,0);
    add(1,0,0,16'h0000, 0,16'h0010,1,16'h0000,0);
    for (int i = 0; i < 4; i++) add(1,0,0,16'h0000, 0,16'h0010,1,16'h0000,0);
    // Decode resumes: buffered PCs drain in order, fetch restarts after first pop.
    add(1,1,0,16'h0000, 0,16'h0010,1,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0010,1,16'h0004,0);
    add(1,1,0,16'h0000, 1,16'h0014,1,16'h0008,0);
    add(1,1,0,16'h0000, 1,16'h0018,1,16'h000C,0);
    // Stall to build 3 entries plus one in flight, then redirect to 0x0100.
    add(1,0,0,16'h0000, 1,16'h001C,1,16'h0010,0);
    add(1,0,1,16'h0100, 0,16'h0020,1,16'h0010,0);
    add(1,1,0,16'h0000, 1,16'h0100,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0104,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0108,1,16'h0100,0);
    // Redirect with a same-cycle pop on a non-empty FIFO, target near the top.
    add(1,1,1,16'hFFF8, 0,16'h010C,1,16'h0104,0);
    add(1,1,0,16'h0000, 1,16'hFFF8,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'hFFFC,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0000,1,16'hFFF8,0);
    add(1,1,0,16'h0000, 1,16'h0004,1,16'hFFFC,0);
    // Misaligned redirect target 0x0102.
    add(1,1,1,16'h0102, 0,16'h0008,1,16'h0000,0);
`ifdef IFU_MISALIGN_CHECK_EN
    add(1,1,0,16'h0000, 0,16'h0102,0,16'h0000,1);
    add(1,1,1,16'h0200, 0,16'h0102,0,16'h0000,1);
    add(1,1,0,16'h0000, 1,16'h0200,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0204,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0208,1,16'h0200,0);
`else
    add(1,1,0,16'h0000, 1,16'h0100,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0104,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0108,1,16'h0100,0);
`endif
    // Redirect while still in IDLE loads the PC.
    add(0,1,0,16'h0000, 0,16'h0000,0,16'h0000,0);
    add(1,1,1,16'h0300, 0,16'h0000,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0300,0,16'h0000,0);
    add(1,1,0,16'h0000, 1,16'h0304,0,16'h0000,0);

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst_enable",  32'(bus.IMEM_ENABLE),  32'h0);
    check("rst_address", 32'(bus.IMEM_ADDRESS), 32'h0000);
    check("rst_valid",   32'(bus.IR_VALID),     32'h0);
    check("rst_ir",      bus.IR,                32'h0);
    check("rst_ir_pc",   32'(bus.IR_PC),        32'h0);
`ifdef IFU_MISALIGN_CHECK_EN
    check("rst_misalign", 32'(bus.MISALIGN),    32'h0);
`endif

    // Vector table, one entry per cycle, checked mid-cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst             = vecs[i].rst;
      bus.IR_READY    = vecs[i].rdy;
      bus.REDIRECT    = vecs[i].redir;
      bus.REDIRECT_PC = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_enable", i),  32'(bus.IMEM_ENABLE),  32'(vecs[i].en));
      check($sformatf("v%0d_address", i), 32'(bus.IMEM_ADDRESS), 32'(vecs[i].addr));
      check($sformatf("v%0d_valid", i),   32'(bus.IR_VALID),     32'(vecs[i].valid));
      check($sformatf("v%0d_ir_pc", i),   32'(bus.IR_PC),        32'(vecs[i].irpc));
      check($sformatf("v%0d_ir", i), bus.IR,
            vecs[i].valid ? rom_word(vecs[i].irpc) : 32'h0);
`ifdef IFU_MISALIGN_CHECK_EN
      check($sformatf("v%0d_misalign", i), 32'(bus.MISALIGN), 32'(vecs[i].mis));
`endif
    end

    // Fetch latency: first IR_VALID three cycles after reset release.
    @(negedge clk);
    rst          = 1'b0;
    bus.REDIRECT = 1'b0;
    bus.IR_READY = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    begin
      int n = 0;
      #1;
      while (!bus.IR_VALID && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("latency_cycles", 32'(n), 32'd3);
      check("latency_ir",     bus.IR, 32'h2001_0005);
      check("latency_ir_pc",  32'(bus.IR_PC), 32'h0000);
    end

    // Asynchronous reset just after a rising edge clears outputs immediately.
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid",   32'(bus.IR_VALID),     32'h0);
    check("async_rst_enable",  32'(bus.IMEM_ENABLE),  32'h0);
    check("async_rst_address", 32'(bus.IMEM_ADDRESS), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the DLX test-bench datapath. It owns the program counter, issues word reads to the instruction ROM, and buffers the returned words with their PCs in a small FIFO for the decode stage. It also handles branch/jump redirects by flushing buffered and in-flight fetches.

## Interface
- ADDRESS_SIZE, 16: instruction address width (byte address).
- WORD_SIZE, 32: instruction width; PC step is WORD_SIZE/8.
- FIFO_DEPTH, 4: instruction buffer entries; must be a power of 2 and at least 2.
- RESET_PC, 0: PC loaded at reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- IMEM_ADDRESS  out  ADDRESS_SIZE  ROM read address, driven directly by the PC register.
- IMEM_ENABLE  out  1  ROM read request, combinational (see Operation).
- IMEM_DATA_READY  in  1  ROM response valid, one cycle after IMEM_ENABLE.
- IMEM_DATA  in  WORD_SIZE  ROM response word.
- REDIRECT  in  1  branch/jump taken; flushes the unit.
- REDIRECT_PC  in  ADDRESS_SIZE  new fetch address.
- IR_READY  in  1  decode accepts the head entry.
- IR_VALID  out  1  FIFO non-empty.
- IR  out  WORD_SIZE  head instruction word.
- IR_PC  out  ADDRESS_SIZE  PC of the head instruction.
- MISALIGN  out  1  sticky misaligned-redirect flag; present only with IFU_MISALIGN_CHECK_EN.

## Operation
- FSM states:
  - IDLE: entered on reset; goes to RUN on the first clock edge after rst deasserts.
  - RUN: normal fetch.
  - HALT: misalignment trap, only with the macro compiled in.
- Internal state:
  - pc
  - req_pc: PC of the in-flight request.
  - inflight: one bit.
  - drop: one bit.
  - FIFO with count 0..FIFO_DEPTH.
- IMEM_ENABLE = (state==RUN) and !REDIRECT and (count + inflight < FIFO_DEPTH). There is no same-cycle pop bypass.
- When a request is issued:
  - req_pc <= pc
  - pc <= pc + WORD_SIZE/8, wrapping modulo 2^ADDRESS_SIZE
  - inflight <= 1
- If no request is issued, inflight <= 0.
- Push: IMEM_DATA_READY and inflight and !drop writes {IMEM_DATA, req_pc} to the FIFO tail. IMEM_DATA_READY with inflight=0 is ignored.
- Pop: IR_VALID and IR_READY advances the head.
- Push and pop in the same cycle leave count unchanged. Overflow cannot occur, because slots are reserved through inflight.
- Pop when empty is ignored.
- REDIRECT (highest priority) has these effects:
  - FIFO is cleared, and any same-cycle push and pop are discarded.
  - pc <= REDIRECT_PC.
  - drop <= inflight, so the response arriving next cycle is discarded.
  - drop clears after one cycle.
- REDIRECT in IDLE still loads the PC.
- Asynchronous reset mid-operation clears all state immediately. The in-flight response is lost.

## Timing
- Reset values:
  - IMEM_ENABLE 0
  - IMEM_ADDRESS RESET_PC
  - IR_VALID 0
  - IR 0
  - IR_PC 0
  - MISALIGN 0
  - count 0
  - inflight 0
  - drop 0
- Fetch latency: IMEM_ENABLE in cycle n, IMEM_DATA_READY in n+1, IR_VALID in n+2.
- Sustained throughput is one instruction per cycle when decode pops every cycle and FIFO_DEPTH >= 2.
- Redirect asserted in cycle r:
  - IR_VALID is 0 in r+1.
  - IMEM_ADDRESS = REDIRECT_PC with IMEM_ENABLE=1 in r+1.
  - First new IR_VALID appears in r+3.
- Backpressure: with IR_READY held low, IMEM_ENABLE drops once count + inflight reaches FIFO_DEPTH. It rises again in the cycle after the first pop.

## Configuration
- IFU_MISALIGN_CHECK_EN defined:
  - A REDIRECT with REDIRECT_PC[log2(WORD_SIZE/8)-1:0] != 0 sets MISALIGN (sticky) and moves the FSM to HALT.
  - HALT issues no requests and flushes the FIFO.
  - A later aligned REDIRECT clears MISALIGN and returns the FSM to RUN.
  - Reset also clears MISALIGN.
- Undefined:
  - The MISALIGN port and the HALT state do not exist.
  - Low REDIRECT_PC bits are forced to zero when loaded into pc.

## Test plan
- Reset release, RESET_PC=0x0000, ROM holds 0x20010005 at 0x0000, IR_READY=1 -> IMEM_ENABLE rises 1 cycle after release; IR=0x20010005 with IR_PC=0x0000 two cycles later, then IR_PC 0x0004, 0x0008 on consecutive cycles.
- IR_READY=0 for 10 cycles -> exactly 4 words buffered and IMEM_ENABLE low; raising IR_READY yields PCs 0x0000..0x000C in order, no gaps or duplicates.
- REDIRECT=1, REDIRECT_PC=0x0100 while a request is in flight and 3 entries are buffered -> IR_VALID=0 next cycle, stale response dropped, first IR_PC=0x0100 three cycles after redirect.
- pc=0xFFFC fetch sequence -> next request address 0x0000 (wrap).
- REDIRECT together with IR_READY on a non-empty FIFO -> flush wins; no stale IR appears.
- With IFU_MISALIGN_CHECK_EN, REDIRECT_PC=0x0102 -> MISALIGN=1, IMEM_ENABLE=0; then REDIRECT_PC=0x0200 -> MISALIGN=0, fetch resumes at 0x0200. Without the macro, REDIRECT_PC=0x0102 -> fetch from 0x0100.
